// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Packs field-level instruction requests into 32-bit ISA words,
//            range-checks them, queues them and streams them into imem.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_func3,
    input  logic [10:0]       in_func11,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              start,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              wrapped,
    output logic [ADDR_W:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] c_OP_A = 3'b000;
    localparam logic [2:0] c_OP_B = 3'b001;
    localparam logic [2:0] c_OP_C = 3'b010;
    localparam logic [2:0] c_OP_D = 3'b011;
    localparam logic [2:0] c_OP_F = 3'b101;
    localparam logic [2:0] c_OP_G = 3'b110;

    localparam logic [1:0] c_ERR_NONE  = 2'd0;
    localparam logic [1:0] c_ERR_OP    = 2'd1;
    localparam logic [1:0] c_ERR_RANGE = 2'd2;
    localparam logic [1:0] c_ERR_ALIGN = 2'd3;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_WRITE = 1'b1;

    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_wrapped;
    logic              r_err_valid;
    logic [1:0]        r_err_code;

    logic [31:0]       w_word;
    logic [1:0]        w_err;
    logic              w_fits16;
    logic              w_fits18;
    logic              w_fits21;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W:0]    w_level;
    logic [PTR_W:0]    w_level_next;

    // Signed range test: every bit above the field's sign bit must match it.
    assign w_fits16 = (&in_imm[31:15]) | ~(|in_imm[31:15]);
    assign w_fits18 = (&in_imm[31:17]) | ~(|in_imm[31:17]);
    assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_word      = '0;
        w_err       = c_ERR_NONE;
        w_word[2:0] = in_op;
        w_word[5:3] = in_func3;
        case (in_op)
            c_OP_A: begin
                w_word[10:6]  = in_rd;
                w_word[15:11] = in_rs1;
                w_word[20:16] = in_rs2;
                w_word[31:21] = in_func11;
            end
            c_OP_B, c_OP_F: begin
                w_word[10:6]  = in_rd;
                w_word[15:11] = in_rs1;
                w_word[31:16] = in_imm[15:0];
                // Zero-extended shift forms of B take an unsigned 16-bit amount.
                if (in_op == c_OP_B && (in_func3 == 3'b101 || in_func3 == 3'b110)) begin
                    if (in_imm[31:16] != 16'd0) w_err = c_ERR_RANGE;
                end else if (!w_fits16) begin
                    w_err = c_ERR_RANGE;
                end
            end
            c_OP_C: begin
                w_word[15:11] = in_rs1;
                w_word[20:16] = in_rs2;
                w_word[10:6]  = in_imm[4:0];
                w_word[31:21] = in_imm[15:5];
                if (!w_fits16) w_err = c_ERR_RANGE;
            end
            c_OP_G: begin
                w_word[15:11] = in_rs1;
                w_word[20:16] = in_rs2;
                w_word[10:6]  = in_imm[6:2];
                w_word[31:21] = in_imm[17:7];
                if (in_imm[1:0] != 2'b00) w_err = c_ERR_ALIGN;
                else if (!w_fits18)       w_err = c_ERR_RANGE;
            end
            c_OP_D: begin
                w_word[10:6]  = in_rd;
                w_word[31:11] = in_imm[20:0];
                if (!w_fits21) w_err = c_ERR_RANGE;
            end
            default: w_err = c_ERR_OP;
        endcase
    end

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign in_ready     = !w_full && !start;
    assign w_accept     = in_valid && in_ready;
    assign w_push       = w_accept && (w_err == c_ERR_NONE);
    assign w_pop        = imem_we && imem_ready && !start;
    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign w_level_next = w_level + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word;
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_addr      <= c_BASE;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_err_valid <= w_accept && (w_err != c_ERR_NONE);
            r_err_code  <= w_accept ? w_err : c_ERR_NONE;
            if (start) begin
                r_state   <= c_S_IDLE;
                r_addr    <= c_BASE;
                r_count   <= '0;
                r_wrapped <= 1'b0;
            end else begin
                case (r_state)
                    c_S_IDLE:  if (!w_empty) r_state <= c_S_WRITE;
                    c_S_WRITE: if (w_pop && w_level_next == '0) r_state <= c_S_IDLE;
                    default:   r_state <= c_S_IDLE;
                endcase
                if (w_pop) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (r_addr == {ADDR_W{1'b1}}) r_wrapped <= 1'b1;
                    if (r_count != c_COUNT_MAX) r_count <= r_count + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign imem_we    = (r_state == c_S_WRITE);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign wrapped    = r_wrapped;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Brief    : Directed self-checking bench for instr_encoder_loader with a
//            queue-based reference model checked on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [2:0]        in_func3;
    logic [10:0]       in_func11;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              start;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              err_valid;
    logic [1:0]        err_code;
    logic              wrapped;
    logic [ADDR_W:0]   count;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_func3(in_func3), .in_func11(in_func11),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .start(start), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .err_valid(err_valid), .err_code(err_code),
        .wrapped(wrapped), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    // Encoding written straight from the field layout using integer arithmetic.
    function automatic void model_encode(input int op, input int f3, input int f11,
                                         input int rd, input int rs1, input int rs2,
                                         input int imm, output logic [31:0] word,
                                         output int err);
        longint v;
        longint w;
        longint f;
        v   = imm;
        w   = op + f3 * 8;
        f   = 0;
        err = 0;
        case (op)
            0: w += rd * 64 + rs1 * 2048 + rs2 * 65536 + f11 * 2097152;
            1, 5: begin
                w += rd * 64 + rs1 * 2048 + (v & 'hFFFF) * 65536;
                if (op == 1 && (f3 == 5 || f3 == 6)) begin
                    if (v < 0 || v > 65535) err = 2;
                end else if (v < -32768 || v > 32767) begin
                    err = 2;
                end
            end
            2, 6: begin
                if (op == 6) begin
                    if (v % 4 != 0) err = 3;
                    else if (v < -131072 || v > 131071) err = 2;
                    f = (v >>> 2) & 'hFFFF;
                end else begin
                    if (v < -32768 || v > 32767) err = 2;
                    f = v & 'hFFFF;
                end
                w += rs1 * 2048 + rs2 * 65536 + (f % 32) * 64 + (f / 32) * 2097152;
            end
            3: begin
                w += rd * 64 + (v & 'h1FFFFF) * 2048;
                if (v < -1048576 || v > 1048575) err = 2;
            end
            default: err = 1;
        endcase
        word = w[31:0];
    endfunction

    logic [31:0] m_q [$];
    int          m_addr;
    int          m_count;
    bit          m_wrapped;
    bit          m_err_v;
    int          m_err_c;
    int          m_idle;
    bit          m_nxt_err_v;
    bit          m_accept;
    logic [31:0] m_word;
    int          m_err;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_we", imem_we, 0);
            chk("rst_addr", imem_addr, BASE_ADDR);
            chk("rst_wdata", imem_wdata, 0);
            chk("rst_count", count, 0);
            chk("rst_wrapped", wrapped, 0);
            chk("rst_err_valid", err_valid, 0);
            m_q.delete();
            m_addr    = BASE_ADDR;
            m_count   = 0;
            m_wrapped = 0;
            m_err_v   = 0;
            m_err_c   = 0;
            m_idle    = 0;
        end else begin
            chk("in_ready", in_ready, (m_q.size() < DEPTH) && !start);
            chk("err_valid", err_valid, m_err_v);
            if (m_err_v) chk("err_code", err_code, m_err_c);
            chk("addr", imem_addr, m_addr);
            chk("count", count, m_count);
            chk("wrapped", wrapped, m_wrapped);
            if (imem_we) begin
                m_idle = 0;
                if (m_q.size() == 0) chk("we_when_empty", imem_we, 0);
                else chk("wdata", imem_wdata, m_q[0]);
            end else if (m_q.size() > 0) begin
                m_idle++;
                chk("write_latency", m_idle <= 1, 1);
            end else begin
                m_idle = 0;
            end

            m_nxt_err_v = 0;
            if (start) begin
                m_q.delete();
                m_addr    = BASE_ADDR;
                m_count   = 0;
                m_wrapped = 0;
            end else begin
                m_accept = in_valid && (m_q.size() < DEPTH);
                if (imem_we && imem_ready && m_q.size() > 0) begin
                    m_word = m_q.pop_front();
                    if (m_addr == (1 << ADDR_W) - 1) begin
                        m_addr    = 0;
                        m_wrapped = 1;
                    end else begin
                        m_addr++;
                    end
                    if (m_count < (1 << ADDR_W)) m_count++;
                end
                if (m_accept) begin
                    model_encode(in_op, in_func3, in_func11, in_rd, in_rs1, in_rs2,
                                 in_imm, m_word, m_err);
                    if (m_err == 0) m_q.push_back(m_word);
                    else begin
                        m_nxt_err_v = 1;
                        m_err_c     = m_err;
                    end
                end
            end
            m_err_v = m_nxt_err_v;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [10:0] f11,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        bit done;
        done      = 0;
        in_op     = op;
        in_func3  = f3;
        in_func11 = f11;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_timeout", done, 1);
    endtask

    task automatic expect_write(input string name, input int addr, input logic [31:0] data);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (imem_we && imem_ready) begin
                got = 1;
                chk({name, "_addr"}, imem_addr, addr);
                chk({name, "_data"}, imem_wdata, data);
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_timeout"}, got, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        chk("start_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    bit acc5;

    initial begin
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; imem_ready = 1'b0;
        in_op = '0; in_func3 = '0; in_func11 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        wait_cycles(2);
        chk("reset_we", imem_we, 0);
        chk("reset_addr", imem_addr, 0);
        chk("reset_wdata", imem_wdata, 0);
        chk("reset_count", count, 0);
        chk("reset_err", {err_valid, err_code}, 0);
        chk("reset_wrapped", wrapped, 0);
        rst = 1'b0;
        wait_cycles(1);
        chk("ready_after_reset", in_ready, 1);

        // Encoding of A and B
        imem_ready = 1'b1;
        send(3'd0, 3'd0, 11'd0, 5'd3, 5'd1, 5'd2, 32'h0001_2345);
        expect_write("t1_a", 0, 32'h0002_08C0);
        send(3'd1, 3'd0, 11'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        expect_write("t1_b", 1, 32'hFFFF_0141);
        chk("t1_count", count, 2);

        // Branch encoding and misaligned offset
        send(3'd6, 3'd1, 11'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        expect_write("t2_g", 2, 32'hFFE2_0F8E);
        send(3'd6, 3'd1, 11'd0, 5'd0, 5'd1, 5'd2, 32'd6);
        chk("t2_err_valid", err_valid, 1);
        chk("t2_err_code", err_code, 3);
        wait_cycles(3);
        chk("t2_addr", imem_addr, 3);
        chk("t2_count", count, 3);
        chk("t2_no_write", imem_we, 0);

        // Reserved op, range errors, unsigned shift amount, boundaries
        send(3'd4, 3'd0, 11'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        chk("t3_op_code", err_code, 1);
        send(3'd1, 3'd0, 11'd0, 5'd1, 5'd1, 5'd0, 32'd40000);
        chk("t3_range_code", err_code, 2);
        send(3'd1, 3'd5, 11'd0, 5'd0, 5'd0, 5'd0, 32'd40000);
        expect_write("t3_shift", 3, 32'h9C40_0029);
        chk("t3_wrapped", wrapped, 1);
        chk("t3_count_sat", count, 4);
        send(3'd3, 3'd0, 11'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
        chk("t3_d_range", err_code, 2);
        send(3'd3, 3'd0, 11'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000);
        expect_write("t3_d_min", 0, 32'h8000_0043);
        send(3'd6, 3'd0, 11'd0, 5'd0, 5'd0, 5'd0, 32'h0002_0000);
        chk("t3_g_range", err_code, 2);
        send(3'd2, 3'd0, 11'd0, 5'd0, 5'd2, 5'd3, 32'hFFFF_8000);
        expect_write("t3_c_min", 1, 32'h8003_1002);

        // Backpressure with a full FIFO
        pulse_start();
        chk("t4_start_count", count, 0);
        chk("t4_start_addr", imem_addr, 0);
        imem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(3'd2, 3'd0, 11'd0, 5'd0, 5'd1, 5'd1, 32'(k));
        chk("t4_full", in_ready, 0);
        in_op = 3'd1; in_func3 = 3'd0; in_rd = 5'd7; in_rs1 = 5'd0; in_imm = 32'd100;
        in_valid = 1'b1;
        wait_cycles(3);
        chk("t4_hold_we", imem_we, 1);
        chk("t4_hold_data", imem_wdata, 32'h0001_0842);
        imem_ready = 1'b1;
        acc5 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_consec", imem_we, 1);
            if (in_valid && in_ready) acc5 = 1;
            @(posedge clk);
            #1;
            if (acc5) in_valid = 1'b0;
        end
        chk("t4_fifth_acc", acc5, 1);
        expect_write("t4_fifth", 0, 32'h0064_01C1);
        chk("t5_wrapped", wrapped, 1);
        chk("t5_count", count, 4);
        chk("t5_addr", imem_addr, 1);

        // start flushes queued words; handshake in the start cycle is dropped
        pulse_start();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(3'd0, 3'd0, 11'd0, 5'(k), 5'd0, 5'd0, 32'd0);
        wait_cycles(2);
        start = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("t6_start_ready", in_ready, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6_we", imem_we, 0);
        chk("t6_count", count, 0);
        chk("t6_addr", imem_addr, 0);
        wait_cycles(3);
        chk("t6_flushed", imem_we, 0);

        // Asynchronous reset in the middle of a write
        send(3'd0, 3'd0, 11'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        expect_write("t6_post_start", 0, 32'h0000_0040);
        imem_ready = 1'b0;
        send(3'd0, 3'd0, 11'd0, 5'd2, 5'd0, 5'd0, 32'd0);
        send(3'd0, 3'd0, 11'd0, 5'd3, 5'd0, 5'd0, 32'd0);
        wait_cycles(2);
        chk("t6_pre_rst_we", imem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_we", imem_we, 0);
        chk("t6_rst_addr", imem_addr, 0);
        chk("t6_rst_wdata", imem_wdata, 0);
        chk("t6_rst_count", count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ready = 1'b1;
        wait_cycles(3);
        chk("t6_lost", imem_we, 0);
        send(3'd0, 3'd0, 11'd0, 5'd4, 5'd0, 5'd0, 32'd0);
        expect_write("t6_after_rst", 0, 32'h0000_0100);

        wait_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
